// File: rtl/trng_map_pkg.sv
// Shared types and constants for the TRNG select-map writer.
//   NUM_ENTRIES / SEL_W / ADDR_W : map geometry
//   map_state_e                  : writer FSM states
//   map_image_t                  : full 16 x 3-bit map image
//   popcount()                   : number of set bits in an entry mask
package trng_map_pkg;

    localparam int unsigned NUM_ENTRIES = 16;
    localparam int unsigned SEL_W       = 3;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned IMG_W       = NUM_ENTRIES * SEL_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } map_state_e;

    typedef logic [NUM_ENTRIES-1:0][SEL_W-1:0] map_image_t;

    // Number of set bits in an entry mask (0..NUM_ENTRIES).
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ENTRIES-1:0] m);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            cnt = cnt + CNT_W'(m[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/trng_map_pick2.sv
// Combinational finder of the two lowest set bits of an entry mask.
//   mask_i  : entry mask
//   a_o     : index of lowest set bit (0 when none)
//   b_o     : index of next-lowest set bit (0 when none)
//   has_a_o : at least one bit set
//   has_b_o : at least two bits set
module trng_map_pick2
    import trng_map_pkg::*;
(
    input  logic [NUM_ENTRIES-1:0] mask_i,
    output logic [ADDR_W-1:0]      a_o,
    output logic [ADDR_W-1:0]      b_o,
    output logic                   has_a_o,
    output logic                   has_b_o
);

    logic [NUM_ENTRIES-1:0] rest;

    // Scan high-to-low so the last hit is the lowest index.
    always_comb begin
        a_o  = '0;
        b_o  = '0;
        rest = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (mask_i[i]) a_o = ADDR_W'(i);
        end
        rest = mask_i & ~(NUM_ENTRIES'(1) << a_o);
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (rest[i]) b_o = ADDR_W'(i);
        end
    end

    assign has_a_o = |mask_i;
    assign has_b_o = |rest;

endmodule

// File: rtl/trng_map_writer.sv
// Initiator for the TRNG select-map write port. Accepts a full map image,
// diffs it against a shadow of the map core contents and streams only the
// changed entries to the core, two per cycle.
//   clk, rst                    : clock, synchronous active-high reset
//   cfg_valid/cfg_ready         : image handshake
//   cfg_image, cfg_force_all    : image and write-all request (captured on accept)
//   busy, done                  : job in progress / one-cycle completion pulse
//   write_count                 : entries written by the last job
//   shadow                      : image the map core holds
//   valid, trng_sel1/2,
//   trng_sel1adress/2adress     : map core write port (two entries per strobe)
module trng_map_writer
    import trng_map_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [IMG_W-1:0]   cfg_image,
    input  logic               cfg_force_all,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   write_count,
    output logic [IMG_W-1:0]   shadow,
    output logic               valid,
    output logic [SEL_W-1:0]   trng_sel1,
    output logic [SEL_W-1:0]   trng_sel2,
    output logic [ADDR_W-1:0]  trng_sel1adress,
    output logic [ADDR_W-1:0]  trng_sel2adress
);

    map_state_e             state_q, state_d;
    map_image_t             img_q, img_d;
    map_image_t             shadow_q, shadow_d;
    logic                   force_q, force_d;
    logic [NUM_ENTRIES-1:0] dirty_q, dirty_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       wcount_q, wcount_d;
    logic                   valid_q, valid_d;
    logic [SEL_W-1:0]       sel1_q, sel1_d, sel2_q, sel2_d;
    logic [ADDR_W-1:0]      addr1_q, addr1_d, addr2_q, addr2_d;

    logic [NUM_ENTRIES-1:0] new_mask;
    logic [NUM_ENTRIES-1:0] pick_src;
    logic [NUM_ENTRIES-1:0] clr_mask;
    logic [ADDR_W-1:0]      pick_a, pick_b, pick_b_eff;
    logic                   pick_has_a, pick_has_b;

    // Entries that differ from what the core holds (or all, when forced).
    always_comb begin
        new_mask = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            new_mask[i] = force_q | (img_q[i] != shadow_q[i]);
        end
    end

    // The pair for the next WRITE cycle is registered one edge ahead, so in
    // LOAD the picker looks at the fresh diff instead of the stored mask.
    assign pick_src = (state_q == LOAD) ? new_mask : dirty_q;

    trng_map_pick2 u_pick2 (
        .mask_i  (pick_src),
        .a_o     (pick_a),
        .b_o     (pick_b),
        .has_a_o (pick_has_a),
        .has_b_o (pick_has_b)
    );

    assign pick_b_eff = pick_has_b ? pick_b : pick_a;
    assign clr_mask   = (NUM_ENTRIES'(1) << pick_a) | (NUM_ENTRIES'(1) << pick_b_eff);

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        img_d    = img_q;
        force_d  = force_q;
        shadow_d = shadow_q;
        dirty_d  = dirty_q;
        cnt_d    = cnt_q;
        wcount_d = wcount_q;
        valid_d  = 1'b0;
        sel1_d   = sel1_q;
        sel2_d   = sel2_q;
        addr1_d  = addr1_q;
        addr2_d  = addr2_q;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    img_d   = map_image_t'(cfg_image);
                    force_d = cfg_force_all;
                    state_d = LOAD;
                end
            end
            LOAD, WRITE: begin
                if (state_q == LOAD) begin
                    cnt_d = popcount(new_mask);
                end else begin
                    // The pair on the port is captured by the core at this edge.
                    shadow_d[addr1_q] = sel1_q;
                    shadow_d[addr2_q] = sel2_q;
                end
                if (pick_has_a) begin
                    valid_d = 1'b1;
                    addr1_d = pick_a;
                    addr2_d = pick_b_eff;
                    sel1_d  = img_q[pick_a];
                    sel2_d  = img_q[pick_b_eff];
                    dirty_d = pick_src & ~clr_mask;
                    state_d = WRITE;
                end else begin
                    dirty_d  = '0;
                    wcount_d = (state_q == LOAD) ? popcount(new_mask) : cnt_q;
                    state_d  = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            img_q    <= '0;
            force_q  <= 1'b0;
            shadow_q <= '0;
            dirty_q  <= '0;
            cnt_q    <= '0;
            wcount_q <= '0;
            valid_q  <= 1'b0;
            sel1_q   <= '0;
            sel2_q   <= '0;
            addr1_q  <= '0;
            addr2_q  <= '0;
        end else begin
            state_q  <= state_d;
            img_q    <= img_d;
            force_q  <= force_d;
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
            cnt_q    <= cnt_d;
            wcount_q <= wcount_d;
            valid_q  <= valid_d;
            sel1_q   <= sel1_d;
            sel2_q   <= sel2_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
        end
    end

    assign cfg_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FIN);
    assign write_count     = wcount_q;
    assign shadow          = shadow_q;
    assign valid           = valid_q;
    assign trng_sel1       = sel1_q;
    assign trng_sel2       = sel2_q;
    assign trng_sel1adress = addr1_q;
    assign trng_sel2adress = addr2_q;

endmodule

// File: tb/tb_trng_map_writer.sv
// Directed + randomized bench for trng_map_writer. A reference model keeps
// the map contents as a plain image and derives the expected write pairs
// from an ascending list of changed entry indices.
module tb_trng_map_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [47:0] cfg_image = '0;
    logic        cfg_force_all = 1'b0;
    logic        busy;
    logic        done;
    logic [4:0]  write_count;
    logic [47:0] shadow;
    logic        valid;
    logic [2:0]  trng_sel1, trng_sel2;
    logic [3:0]  trng_sel1adress, trng_sel2adress;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] model_img = '0;

    always #5 clk = ~clk;

    trng_map_writer dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_image       (cfg_image),
        .cfg_force_all   (cfg_force_all),
        .busy            (busy),
        .done            (done),
        .write_count     (write_count),
        .shadow          (shadow),
        .valid           (valid),
        .trng_sel1       (trng_sel1),
        .trng_sel2       (trng_sel2),
        .trng_sel1adress (trng_sel1adress),
        .trng_sel2adress (trng_sel2adress)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        model_img = '0;
    endtask

    // One full job: accept, LOAD, ceil(n/2) WRITE cycles, FIN, back to IDLE.
    task automatic run_job(input logic [47:0] img, input logic frc);
        int q[$];
        int a, b, n;
        int last_a, last_b;
        logic [47:0] noise;
        for (int i = 0; i < 16; i++) begin
            if (frc || (img[3*i +: 3] != model_img[3*i +: 3])) q.push_back(i);
        end
        n = q.size();
        last_a = 0;
        last_b = 0;
        chk("ready_idle", 48'(cfg_ready), 48'd1);
        cfg_valid     = 1'b1;
        cfg_image     = img;
        cfg_force_all = frc;
        step();
        // LOAD cycle; keep cfg_valid high with junk to show it is ignored
        noise         = 48'({$urandom(), $urandom()});
        cfg_image     = noise;
        cfg_force_all = 1'($urandom);
        chk("load_busy", 48'(busy), 48'd1);
        chk("load_ready", 48'(cfg_ready), 48'd0);
        chk("load_valid", 48'(valid), 48'd0);
        while (q.size() > 0) begin
            a = q.pop_front();
            b = (q.size() > 0) ? q.pop_front() : a;
            step();
            chk("wr_valid", 48'(valid), 48'd1);
            chk("wr_done", 48'(done), 48'd0);
            chk("wr_addr1", 48'(trng_sel1adress), 48'(a));
            chk("wr_addr2", 48'(trng_sel2adress), 48'(b));
            chk("wr_sel1", 48'(trng_sel1), 48'(img[3*a +: 3]));
            chk("wr_sel2", 48'(trng_sel2), 48'(img[3*b +: 3]));
            model_img[3*a +: 3] = img[3*a +: 3];
            model_img[3*b +: 3] = img[3*b +: 3];
            last_a = a;
            last_b = b;
        end
        step();
        cfg_valid = 1'b0;
        chk("fin_done", 48'(done), 48'd1);
        chk("fin_valid", 48'(valid), 48'd0);
        chk("fin_wcount", 48'(write_count), 48'(n));
        chk("fin_shadow", shadow, model_img);
        if (n > 0) begin
            chk("hold_addr1", 48'(trng_sel1adress), 48'(last_a));
            chk("hold_addr2", 48'(trng_sel2adress), 48'(last_b));
        end
        step();
        chk("idle_done", 48'(done), 48'd0);
        chk("idle_ready", 48'(cfg_ready), 48'd1);
        chk("idle_busy", 48'(busy), 48'd0);
        chk("idle_wcount", 48'(write_count), 48'(n));
    endtask

    initial begin
        logic [47:0] img;
        logic [47:0] all7;
        all7 = '0;
        for (int i = 0; i < 16; i++) all7[3*i +: 3] = 3'd7;

        // Reset state
        do_reset();
        chk("rst_ready", 48'(cfg_ready), 48'd1);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_done", 48'(done), 48'd0);
        chk("rst_valid", 48'(valid), 48'd0);
        chk("rst_wcount", 48'(write_count), 48'd0);
        chk("rst_shadow", shadow, 48'd0);
        chk("rst_sel1", 48'(trng_sel1), 48'd0);
        chk("rst_addr2", 48'(trng_sel2adress), 48'd0);

        // All-zero image: nothing to write
        run_job(48'd0, 1'b0);

        // Single entry 0 = 5: one duplicated-slot write
        do_reset();
        run_job(48'd5, 1'b0);
        chk("single_shadow", 48'(shadow[2:0]), 48'd5);

        // All 7 from reset, then same image unforced and forced
        do_reset();
        run_job(all7, 1'b0);
        run_job(all7, 1'b0);
        run_job(all7, 1'b1);

        // Entries 3, 9, 12 -> 1
        img = all7;
        img[9 +: 3]  = 3'd1;
        img[27 +: 3] = 3'd1;
        img[36 +: 3] = 3'd1;
        run_job(img, 1'b0);

        // Random jobs: mostly small diffs, sometimes full random or forced
        for (int k = 0; k < 40; k++) begin
            img = model_img;
            if ($urandom_range(0, 3) == 0) begin
                img = 48'({$urandom(), $urandom()});
            end else begin
                for (int m = 0; m < int'($urandom_range(0, 5)); m++) begin
                    img[3*$urandom_range(0, 15) +: 3] = 3'($urandom);
                end
            end
            run_job(img, ($urandom_range(0, 7) == 0));
        end

        // Reset during the 3rd WRITE cycle of the all-7 job
        do_reset();
        cfg_valid = 1'b1;
        cfg_image = all7;
        cfg_force_all = 1'b0;
        step();                  // LOAD
        cfg_valid = 1'b0;
        step();                  // WRITE 1
        step();                  // WRITE 2
        step();                  // WRITE 3
        chk("abort_w3_valid", 48'(valid), 48'd1);
        chk("abort_w3_addr1", 48'(trng_sel1adress), 48'd4);
        rst = 1'b1;
        step();
        chk("abort_valid", 48'(valid), 48'd0);
        chk("abort_shadow", shadow, 48'd0);
        chk("abort_ready", 48'(cfg_ready), 48'd1);
        chk("abort_done", 48'(done), 48'd0);
        rst = 1'b0;
        model_img = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("abort_no_done", 48'(done), 48'd0);
            chk("abort_no_valid", 48'(valid), 48'd0);
        end

        // Writer still works after the abort
        run_job(all7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
